// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension execute unit.
// Radix-2 shift-add multiply / restoring divide on operand magnitudes,
// one bit per cycle, followed by a single sign fix-up cycle.
// Divide-by-zero and signed overflow complete at the accept edge.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opd_q;   // |a| for multiply, |b| (divisor) for divide
  logic [2*XLEN-1:0] acc;     // mul: {hi, multiplier/lo}; div: low half is the quotient shift reg
  logic [XLEN-1:0]   rem;     // divide partial remainder (always < divisor)

  // ---- request decode (live inputs, used only at the accept edge) ----
  logic            sa, sb, neg_in, b_zero, ovf, early;
  logic [XLEN-1:0] abs_a, abs_b, early_res;

  // Operand signs, magnitudes and the early-out verdict for the incoming request
  always_comb begin
    sa        = a[XLEN-1] & (op[2] ? ~op[0] : (op == 3'b001 || op == 3'b010));
    sb        = b[XLEN-1] & (op[2] ? ~op[0] : (op == 3'b001));
    abs_a     = sa ? (~a + 1'b1) : a;
    abs_b     = sb ? (~b + 1'b1) : b;
    // remainder takes the dividend's sign; everything else takes sa^sb
    neg_in    = (op[2] & op[1]) ? sa : (sa ^ sb);
    b_zero    = (b == '0);
    ovf       = op[2] & ~op[0] & (a == MIN_VAL) & (b == '1);
    early     = op[2] & (b_zero | ovf);
    if (b_zero) early_res = op[1] ? a : '1;
    else        early_res = op[1] ? '0 : MIN_VAL;
  end

  // ---- one iteration of each core, plus the fix-up result ----
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              qbit;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   dval, fix_res;

  // Iteration step and final sign correction
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd_q} : '0);
    div_shift = {rem, acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    qbit      = ~div_diff[XLEN];
    // full-width negate so the low-half carry reaches the high half
    prod      = neg_q ? (~acc + 1'b1) : acc;
    dval      = op_q[1] ? rem : acc[XLEN-1:0];
    if (op_q[2])              fix_res = neg_q ? (~dval + 1'b1) : dval;
    else if (op_q[1:0] == 0)  fix_res = prod[XLEN-1:0];
    else                      fix_res = prod[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) && !flush;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    case (state)
      IDLE: if (in_valid && in_ready) state_nxt = early ? DONE : CALC;
      CALC: if (cnt == CNT_LAST)      state_nxt = FIX;
      FIX:                            state_nxt = DONE;
      DONE: if (out_ready)            state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath: capture at accept, iterate in CALC, publish in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      opd_q   <= '0;
      acc     <= '0;
      rem     <= '0;
      result  <= '0;
      out_tag <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q    <= op;
          out_tag <= in_tag;
          neg_q   <= neg_in;
          cnt     <= '0;
          rem     <= '0;
          opd_q   <= op[2] ? abs_b : abs_a;
          acc     <= {{XLEN{1'b0}}, (op[2] ? abs_a : abs_b)};
          if (early) result <= early_res;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[2]) begin
            rem <= qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], qbit};
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
        end
        FIX:     result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle RV M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, parametrised in XLEN.
- Sits beside the single-cycle ALU in EX. The pipeline stalls on in_ready/out_valid.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle, on magnitudes, with a final sign fix-up cycle.
- Divide-by-zero and signed overflow are resolved early, in one cycle.

Parameters:
- XLEN, 32, operand/result width; power of 2, ≥ 8.
- TAG_W, 5, width of the sideband tag (destination register) carried from input to output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight or pending operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand (multiplicand/dividend).
- b  in  XLEN  rs2 operand (multiplier/divisor).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- out_tag  out  TAG_W  tag captured with the request.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset → IDLE.
- Reset values: out_valid=0, result=0, out_tag=0, busy=0, counter=0, all datapath registers 0. in_ready=1 after reset.
- Output definitions:
  - in_ready = (state==IDLE) && !flush.
  - out_valid = (state==DONE).
  - busy = (state≠IDLE).
- Accept: in_valid && in_ready at an edge. Latch op, a, b and in_tag. Inputs are don't-care afterwards.
- Sign handling:
  - sa = a[XLEN-1] for MULH, MULHSU, DIV, REM.
  - sb = b[XLEN-1] for MULH, DIV, REM.
  - Otherwise sa/sb = 0.
  - Core operands are |a| and |b| (two's-complement negate when the sign bit is set). The core is unsigned.
  - neg_res = sa^sb for MUL*, DIV and DIVU. neg_res = sa for REM and REMU.
- Early-out, decided at the accept edge (state goes directly to DONE, so out_valid is seen 1 edge after accept):
  - DIV/DIVU with b==0: result = all ones.
  - REM/REMU with b==0: result = a.
  - DIV with a==MIN, b==all ones: result = MIN.
  - REM with a==MIN, b==all ones: result = 0.
- Normal path:
  - Accept edge → CALC, counter=0.
  - Each CALC edge performs one iteration and increments the counter.
  - The edge with counter==XLEN-1 performs the last iteration and moves to FIX.
  - FIX edge: conditionally negate the 2·XLEN product or the quotient/remainder, select the result, → DONE.
  - out_valid is first seen XLEN+1 edges after the accept edge (33 for XLEN=32).
- Multiply: 2·XLEN-bit accumulator.
  - MUL returns the low XLEN bits of the signed-corrected product.
  - MULH/MULHSU/MULHU return the high XLEN bits.
  - Negating the full 2·XLEN value is mandatory (carry from the low half).
- Divide: restoring division, XLEN-bit quotient shift register, XLEN+1-bit partial remainder.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE:
  - result and out_tag stay stable while out_valid && !out_ready.
  - Handshake edge → IDLE, so in_ready is high the following cycle.
  - No back-to-back accept in the same cycle as the output handshake.
- flush:
  - Highest priority after reset.
  - From any state, the next edge forces IDLE and clears out_valid and the counter. The result is discarded.
  - An in_valid in the same cycle is not accepted (in_ready is low).
- Reset mid-operation returns immediately (asynchronously) to IDLE with all reset values.
- op is decoded only from the latched copy. Every op value is legal, so there is no illegal-op path.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB; out_valid first high 33 edges after accept; out_tag equals in_tag.
- High-half multiplies, each with latency 33:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide/remainder:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Early-out cases, each with out_valid 1 edge after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result, out_tag and out_valid stable, in_ready=0. Raise out_ready → in_ready=1 next cycle; a new request is accepted.
- Abort and reset:
  - Assert flush at CALC counter=10 → IDLE next edge; out_valid never rises.
  - A concurrent in_valid is not accepted.
  - rst_n low mid-CALC → immediate IDLE, all outputs at reset values.
